// File: rtl/game_timer_if.sv
`default_nettype none
// ============================================================================
//  Module      : game_timer_if
//  Description : Control/status bundle between the game FSM (master) and the
//                round timer (slave).
//                master drives : start, stop, pause
//                slave drives  : game_timer, secs_left, secs_tens, secs_ones,
//                                sec_tick, time_up, busy, timer_state
//  Revision    : 1.0  initial release
// ============================================================================
interface game_timer_if;
   logic       start;        // one-cycle pulse, begins a round
   logic       stop;         // one-cycle pulse, aborts the round
   logic       pause;        // level, freezes the countdown
   logic       game_timer;   // high while secs_left != 0
   logic [6:0] secs_left;    // remaining seconds, binary
   logic [3:0] secs_tens;    // BCD tens digit of secs_left
   logic [3:0] secs_ones;    // BCD ones digit of secs_left
   logic       sec_tick;     // one-cycle pulse on each decrement
   logic       time_up;      // one-cycle pulse when the count reaches 0
   logic       busy;         // high in RUN or PAUSE
   logic [1:0] timer_state;  // IDLE=00 RUN=01 PAUSE=10 DONE=11

   modport master (
      output start, stop, pause,
      input  game_timer, secs_left, secs_tens, secs_ones,
             sec_tick, time_up, busy, timer_state
   );

   modport slave (
      input  start, stop, pause,
      output game_timer, secs_left, secs_tens, secs_ones,
             sec_tick, time_up, busy, timer_state
   );
endinterface
`default_nettype wire

// File: rtl/game_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : game_timer_ctrl
//  Description : Round countdown timer. Loads GAME_SECONDS, counts whole
//                seconds down from pclk, supports pause / abort / restart and
//                presents the remaining time in binary and BCD.
//  Ports       : pclk   - pixel clock, all logic on the rising edge
//                rst_d  - synchronous active-high reset
//                tmr    - game_timer_if.slave (start/stop/pause in,
//                         countdown status out; all outputs registered)
//  Parameters  : CLK_FREQ     - pclk cycles per second
//                GAME_SECONDS - round length, 1..99
//  Revision    : 1.0  initial release
// ============================================================================
module game_timer_ctrl #(
   parameter int CLK_FREQ     = 65_000_000,
   parameter int GAME_SECONDS = 60
) (
   input  wire          pclk,
   input  wire          rst_d,
   game_timer_if.slave  tmr
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_RUN   = 2'b01;
   localparam logic [1:0] S_PAUSE = 2'b10;
   localparam logic [1:0] S_DONE  = 2'b11;

   // Prescaler only ever needs to hold 0..CLK_FREQ-1
   localparam int         PW        = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
   localparam logic [PW-1:0] PRE_TC = PW'(CLK_FREQ - 1);
   localparam logic [PW-1:0] PRE_ONE = PW'(1);

   localparam logic [6:0] SECS_INIT = 7'(GAME_SECONDS);
   localparam logic [3:0] TENS_INIT = 4'(GAME_SECONDS / 10);
   localparam logic [3:0] ONES_INIT = 4'(GAME_SECONDS % 10);

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   logic [1:0]    state_q, state_d;
   logic [PW-1:0] pre_q,   pre_d;
   logic [6:0]    secs_q,  secs_d;
   logic [3:0]    tens_q,  tens_d;
   logic [3:0]    ones_q,  ones_d;
   logic          tick_q,  tick_d;
   logic          tup_q,   tup_d;
   logic          gt_q,    gt_d;
   logic          busy_q,  busy_d;

   logic          tc_w;       // prescaler at terminal count
   logic          last_w;     // the coming tick is the final one

   assign tc_w   = (pre_q == PRE_TC);
   assign last_w = (secs_q == 7'd1);

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge pclk) begin
      if (rst_d) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic. Priority: stop > start > pause > terminal count.
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (!tmr.stop && tmr.start) begin
               state_d = S_RUN;
            end
         end
         S_RUN, S_PAUSE: begin
            // start is ignored mid-round
            if (tmr.stop) begin
               state_d = S_IDLE;
            end else if (tmr.pause) begin
               state_d = S_PAUSE;
            end else if (tc_w && last_w) begin
               state_d = S_DONE;
            end else begin
               state_d = S_RUN;
            end
         end
         S_DONE: begin
            if (tmr.stop) begin
               state_d = S_IDLE;
            end else if (tmr.start) begin
               state_d = S_RUN;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Output / datapath next values
   // ------------------------------------------------------------------------
   always_comb begin
      pre_d  = pre_q;
      secs_d = secs_q;
      tens_d = tens_q;
      ones_d = ones_q;
      tick_d = 1'b0;
      tup_d  = 1'b0;

      case (state_q)
         S_RUN, S_PAUSE: begin
            if (tmr.stop) begin
               // abort wins over a coincident terminal count: no tick, no time_up
               pre_d  = '0;
               secs_d = SECS_INIT;
               tens_d = TENS_INIT;
               ones_d = ONES_INIT;
            end else if (tmr.pause) begin
               // hold everything; the held prescaler value resumes later so
               // every paused edge lengthens the current second by one cycle
               pre_d = pre_q;
            end else if (tc_w) begin
               pre_d = '0;
               if (secs_q != 7'd0) begin
                  tick_d = 1'b1;
                  tup_d  = last_w;
                  secs_d = secs_q - 7'd1;
                  if (ones_q == 4'd0) begin
                     ones_d = 4'd9;
                     tens_d = tens_q - 4'd1;
                  end else begin
                     ones_d = ones_q - 4'd1;
                  end
               end
            end else begin
               // a resume edge (PAUSE with pause low) also advances
               pre_d = pre_q + PRE_ONE;
            end
         end
         S_DONE: begin
            pre_d = '0;
            if (tmr.stop || tmr.start) begin
               secs_d = SECS_INIT;
               tens_d = TENS_INIT;
               ones_d = ONES_INIT;
            end
         end
         default: begin
            // IDLE: counter parked at the round length, prescaler cleared
            pre_d  = '0;
            secs_d = SECS_INIT;
            tens_d = TENS_INIT;
            ones_d = ONES_INIT;
         end
      endcase

      gt_d   = (secs_d != 7'd0);
      busy_d = (state_d == S_RUN) || (state_d == S_PAUSE);
   end

   // ------------------------------------------------------------------------
   // Datapath / output registers
   // ------------------------------------------------------------------------
   always_ff @(posedge pclk) begin
      if (rst_d) begin
         pre_q  <= '0;
         secs_q <= SECS_INIT;
         tens_q <= TENS_INIT;
         ones_q <= ONES_INIT;
         tick_q <= 1'b0;
         tup_q  <= 1'b0;
         gt_q   <= 1'b1;
         busy_q <= 1'b0;
      end else begin
         pre_q  <= pre_d;
         secs_q <= secs_d;
         tens_q <= tens_d;
         ones_q <= ones_d;
         tick_q <= tick_d;
         tup_q  <= tup_d;
         gt_q   <= gt_d;
         busy_q <= busy_d;
      end
   end

   assign tmr.game_timer  = gt_q;
   assign tmr.secs_left   = secs_q;
   assign tmr.secs_tens   = tens_q;
   assign tmr.secs_ones   = ones_q;
   assign tmr.sec_tick    = tick_q;
   assign tmr.time_up     = tup_q;
   assign tmr.busy        = busy_q;
   assign tmr.timer_state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_game_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_timer_ctrl
//  Description : Scoreboard bench for game_timer_ctrl. Two instances share the
//                same stimulus: A with a 3 s round, B with a 12 s round.
//                A timeline model predicts, for every cycle, the status and
//                the absolute cycle of every tick.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_game_timer_ctrl;

   localparam int CLK  = 10;
   localparam int GS_A = 3;
   localparam int GS_B = 12;

   logic pclk = 1'b0;
   logic rst_d;

   game_timer_if ifa();
   game_timer_if ifb();

   game_timer_ctrl #(.CLK_FREQ(CLK), .GAME_SECONDS(GS_A)) dut_a (
      .pclk (pclk),
      .rst_d(rst_d),
      .tmr  (ifa)
   );

   game_timer_ctrl #(.CLK_FREQ(CLK), .GAME_SECONDS(GS_B)) dut_b (
      .pclk (pclk),
      .rst_d(rst_d),
      .tmr  (ifb)
   );

   always #5 pclk = ~pclk;

   // ------------------------------------------------------------------------
   // Reference model: mode, seconds left, and the absolute cycle at which the
   // next tick becomes visible. Every held (paused) edge pushes it back by one.
   // ------------------------------------------------------------------------
   typedef struct { int cyc; int secs; bit tup; } ev_t;
   typedef struct { int mode; int secs; } st_t;

   ev_t evq_a[$];
   ev_t evq_b[$];
   st_t stq_a[$];
   st_t stq_b[$];

   int m_mode [2];
   int m_secs [2];
   int m_next [2];
   int gs     [2];
   int cyc;
   int total;
   int bad;

   function automatic void step(int d, bit st, bit sp, bit pa, bit rs);
      ev_t e;
      st_t s;
      bit  tick;
      tick = 1'b0;
      if (rs) begin
         m_mode[d] = 0;
         m_secs[d] = gs[d];
      end else if (m_mode[d] == 0) begin
         if (!sp && st) begin
            m_mode[d] = 1;
            m_secs[d] = gs[d];
            m_next[d] = cyc + 1 + CLK;
         end
      end else if (m_mode[d] == 3) begin
         if (sp) begin
            m_mode[d] = 0;
            m_secs[d] = gs[d];
         end else if (st) begin
            m_mode[d] = 1;
            m_secs[d] = gs[d];
            m_next[d] = cyc + 1 + CLK;
         end
      end else begin
         if (sp) begin
            m_mode[d] = 0;
            m_secs[d] = gs[d];
         end else if (pa) begin
            m_mode[d] = 2;
            m_next[d] = m_next[d] + 1;
         end else begin
            m_mode[d] = 1;
            if (cyc + 1 == m_next[d]) begin
               m_secs[d] = m_secs[d] - 1;
               m_next[d] = m_next[d] + CLK;
               tick      = 1'b1;
               if (m_secs[d] == 0) m_mode[d] = 3;
            end
         end
      end
      if (tick) begin
         e.cyc  = cyc + 1;
         e.secs = m_secs[d];
         e.tup  = (m_secs[d] == 0);
         if (d == 0) evq_a.push_back(e); else evq_b.push_back(e);
      end
      s.mode = m_mode[d];
      s.secs = m_secs[d];
      if (d == 0) stq_a.push_back(s); else stq_b.push_back(s);
   endfunction

   // One cycle of stimulus, applied to both instances
   task automatic drive(input bit st, input bit sp, input bit pa, input bit rs);
      @(negedge pclk);
      rst_d     = rs;
      ifa.start = st;  ifb.start = st;
      ifa.stop  = sp;  ifb.stop  = sp;
      ifa.pause = pa;  ifb.pause = pa;
      step(0, st, sp, pa, rs);
      step(1, st, sp, pa, rs);
      cyc++;
   endtask

   // ------------------------------------------------------------------------
   // Monitor
   // ------------------------------------------------------------------------
   task automatic check_dut(input int d, input logic tick, input logic tup,
                            input logic [1:0] st, input logic busy,
                            input logic gt, input logic [6:0] secs,
                            input logic [3:0] tens, input logic [3:0] ones);
      st_t s;
      ev_t e;
      bit  have;
      logic [20:0] act, exp;
      have = 1'b0;
      if (d == 0) begin
         if (stq_a.size() > 0) begin s = stq_a.pop_front(); have = 1'b1; end
      end else begin
         if (stq_b.size() > 0) begin s = stq_b.pop_front(); have = 1'b1; end
      end
      if (have) begin
         act = {st, busy, gt, secs, tens, ones, 2'b00};
         exp = {2'(s.mode), (s.mode == 1 || s.mode == 2), (s.secs != 0),
                7'(s.secs), 4'(s.secs / 10), 4'(s.secs % 10), 2'b00};
         total++;
         if (act !== exp) begin
            bad++;
            $display("FAIL status dut%0d cyc=%0d got st=%0d busy=%b gt=%b secs=%0d bcd=%0d%0d want st=%0d busy=%b gt=%b secs=%0d bcd=%0d%0d",
                     d, cyc, st, busy, gt, secs, tens, ones,
                     s.mode, exp[18], exp[17], s.secs, s.secs / 10, s.secs % 10);
         end
      end
      if (tick === 1'b1 || tup === 1'b1) begin
         total++;
         have = 1'b0;
         if (d == 0) begin
            if (evq_a.size() > 0) begin e = evq_a.pop_front(); have = 1'b1; end
         end else begin
            if (evq_b.size() > 0) begin e = evq_b.pop_front(); have = 1'b1; end
         end
         if (!have) begin
            bad++;
            $display("FAIL tick dut%0d cyc=%0d got tick=%b time_up=%b want no tick", d, cyc, tick, tup);
         end else if (e.cyc != cyc || tick !== 1'b1 || tup !== e.tup) begin
            bad++;
            $display("FAIL tick dut%0d got cyc=%0d tick=%b time_up=%b want cyc=%0d tick=1 time_up=%b secs=%0d",
                     d, cyc, tick, tup, e.cyc, e.tup, e.secs);
         end
      end
   endtask

   always @(posedge pclk) begin
      #1;
      check_dut(0, ifa.sec_tick, ifa.time_up, ifa.timer_state, ifa.busy,
                ifa.game_timer, ifa.secs_left, ifa.secs_tens, ifa.secs_ones);
      check_dut(1, ifb.sec_tick, ifb.time_up, ifb.timer_state, ifb.busy,
                ifb.game_timer, ifb.secs_left, ifb.secs_tens, ifb.secs_ones);
   end

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   initial begin
      int  t1;
      bit  sp;
      bit  hit;
      bit  pa;
      cyc   = 0;
      total = 0;
      bad   = 0;
      gs[0] = GS_A;
      gs[1] = GS_B;
      rst_d = 1'b1;
      ifa.start = 1'b0; ifa.stop = 1'b0; ifa.pause = 1'b0;
      ifb.start = 1'b0; ifb.stop = 1'b0; ifb.pause = 1'b0;

      // reset, then idle with stop/pause that must be ignored
      repeat (3) drive(0, 0, 0, 1);
      for (int i = 0; i < 6; i++) drive(0, (i == 2), (i >= 3), 0);

      // full round of A; B keeps running
      drive(1, 0, 0, 0);
      repeat (40) drive(0, 0, 0, 0);

      // restart A from DONE; pause for 25 cycles starting 4 after first tick
      t1 = cyc + 1 + CLK;
      drive(1, 0, 0, 0);
      for (int i = 0; i < 80; i++) drive(0, 0, (cyc >= t1 + 4 && cyc < t1 + 29), 0);

      // restart A, abort exactly on its final terminal count
      drive(1, 0, 0, 0);
      hit = 1'b0;
      for (int i = 0; i < 100 && !hit; i++) begin
         sp  = (m_mode[0] == 1 && m_secs[0] == 1 && m_next[0] == cyc + 1);
         hit = sp;
         drive(0, sp, 0, 0);
      end
      total++;
      if (!hit) begin
         bad++;
         $display("FAIL stop_at_tc got no terminal count within 100 cycles want one");
      end
      repeat (5) drive(0, 0, 0, 0);

      // uninterrupted 12 s round for B
      drive(1, 0, 0, 0);
      repeat (130) drive(0, 0, 0, 0);

      // reset while prescaler is 7, then restart
      drive(1, 0, 0, 0);
      repeat (7) drive(0, 0, 0, 0);
      drive(0, 0, 0, 1);
      drive(1, 0, 0, 0);
      repeat (40) drive(0, 0, 0, 0);

      // random traffic
      pa = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 15) == 0) pa = ~pa;
         drive(($urandom_range(0, 24) == 0), ($urandom_range(0, 59) == 0), pa,
               ($urandom_range(0, 299) == 0));
      end
      repeat (5) drive(0, 0, 0, 0);

      @(posedge pclk);
      #2;
      total++;
      if (evq_a.size() != 0 || evq_b.size() != 0) begin
         bad++;
         $display("FAIL missing_ticks got pending a=%0d b=%0d want 0", evq_a.size(), evq_b.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
